// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock-enable divider controller.
package clkdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_DIV    = 2;
  localparam int CNT_W_DEF  = 27;
  localparam int TCNT_W_DEF = 16;

endpackage

// File: rtl/clkdiv_counter.sv
// Period counter: counts 0..div-1 while run is high and predicts the next clk_out level.
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             half
);

  logic [CNT_W-1:0] cnt_d;

  // half compares the next count against the current divisor; a divisor
  // change only happens when cnt_d is zero, which is below any legal half.
  always_comb begin
    wrap  = (cnt == div - CNT_W'(1));
    cnt_d = (run && !wrap) ? cnt + CNT_W'(1) : '0;
    half  = (cnt_d < (div >> 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time divider controller: start/stop FSM, divisor handshake, tick and divided clock.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 72_000_000,
  parameter int TCNT_W  = TCNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              clk_out,
  output logic              tick,
  output logic [TCNT_W-1:0] tick_cnt
);

  state_t           state, state_d;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pend_div;
  logic             pend_v;
  logic [CNT_W-1:0] cnt_unused;
  logic             wrap;
  logic             half;
  logic             run;
  logic             xfer;
  logic             legal;

  clkdiv_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock(clock),
    .reset(reset),
    .run  (run),
    .div  (div_q),
    .cnt  (cnt_unused),
    .wrap (wrap),
    .half (half)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start && !stop) state_d = RUN;
      RUN:     if (stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy      = (state == RUN);
    run       = busy && !stop;
    tick      = busy && wrap;
    cfg_ready = !pend_v;
    xfer      = cfg_valid && cfg_ready;
    legal     = (cfg_div >= CNT_W'(MIN_DIV));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      div_q    <= CNT_W'(DEF_DIV);
      pend_div <= '0;
      pend_v   <= 1'b0;
      clk_out  <= 1'b0;
      tick_cnt <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_d;
      clk_out <= (state_d == RUN) && half;
      cfg_err <= xfer && !legal;
      if (tick) tick_cnt <= tick_cnt + TCNT_W'(1);
      // A legal divisor taken while stopping goes straight to div_q,
      // matching the apply-on-entry-to-IDLE rule for a pending value.
      if (pend_v) begin
        if (tick || stop) begin
          div_q  <= pend_div;
          pend_v <= 1'b0;
        end
      end else if (xfer && legal) begin
        if (state == IDLE || stop) begin
          div_q <= cfg_div;
        end else begin
          pend_div <= cfg_div;
          pend_v   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed self-checking bench for clkdiv_ctrl (divisor 10 instance plus a 4-bit tick counter instance).
module tb_clkdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [26:0] cfg_div = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_ready, cfg_err, busy, clk_out, tick;
  logic [15:0] tick_cnt;

  logic        w_start = 1'b0;
  logic        w_cfg_valid = 1'b0;
  logic [26:0] w_cfg_div = '0;
  logic        w_stop = 1'b0;
  logic        w_cfg_ready, w_cfg_err, w_busy, w_clk_out, w_tick;
  logic [3:0]  w_tick_cnt;

  int checks = 0;
  int errors = 0;
  int exp_tc = 0;

  always #5 clock = ~clock;

  clkdiv_ctrl #(.CNT_W(27), .DEF_DIV(10), .TCNT_W(16)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_err(cfg_err), .start(start), .stop(stop),
    .busy(busy), .clk_out(clk_out), .tick(tick), .tick_cnt(tick_cnt)
  );

  clkdiv_ctrl #(.CNT_W(27), .DEF_DIV(2), .TCNT_W(4)) dut_w (
    .clock(clock), .reset(reset), .cfg_valid(w_cfg_valid), .cfg_ready(w_cfg_ready),
    .cfg_div(w_cfg_div), .cfg_err(w_cfg_err), .start(w_start), .stop(w_stop),
    .busy(w_busy), .clk_out(w_clk_out), .tick(w_tick), .tick_cnt(w_tick_cnt)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || clk_out !== 1'b0 || tick !== 1'b0 || cfg_err !== 1'b0 ||
        cfg_ready !== 1'b1 || tick_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b clk_out=%b tick=%b cfg_err=%b cfg_ready=%b tick_cnt=%0d, expected 0 0 0 0 1 0",
               busy, clk_out, tick, cfg_err, cfg_ready, tick_cnt);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_div10();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL div10_busy: got %b expected 1", busy);
    end
    for (int k = 1; k <= 30; k++) begin
      int p;
      p = (k - 1) % 10;
      checks++;
      if (clk_out !== (p < 5) || tick !== (p == 9)) begin
        errors++;
        $display("FAIL div10_wave k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, p < 5, p == 9);
      end
      if (p == 9) exp_tc++;
      step();
    end
    checks++;
    if (tick_cnt !== 16'(exp_tc)) begin
      errors++;
      $display("FAIL div10_tick_cnt: got %0d expected %0d", tick_cnt, exp_tc);
    end
    do_stop();
    checks++;
    if (busy !== 1'b0 || clk_out !== 1'b0 || tick_cnt !== 16'(exp_tc)) begin
      errors++;
      $display("FAIL div10_stop: busy=%b clk_out=%b tick_cnt=%0d expected 0 0 %0d", busy, clk_out, tick_cnt, exp_tc);
    end
  endtask

  task automatic test_cfg_idle();
    cfg_valid = 1'b1;
    cfg_div   = 27'd3;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg3_accept: cfg_err=%b cfg_ready=%b expected 0 1", cfg_err, cfg_ready);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      int p;
      p = (k - 1) % 3;
      checks++;
      if (clk_out !== (p == 0) || tick !== (p == 2)) begin
        errors++;
        $display("FAIL cfg3_wave k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, p == 0, p == 2);
      end
      if (p == 2) exp_tc++;
      step();
    end
    do_stop();
    // divisor load coinciding with start: first period already uses 10
    cfg_valid = 1'b1;
    cfg_div   = 27'd10;
    start     = 1'b1;
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      int p;
      p = k - 1;
      checks++;
      if (clk_out !== (p < 5) || tick !== (p == 9)) begin
        errors++;
        $display("FAIL cfg_start_wave k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, p < 5, p == 9);
      end
      if (p == 9) exp_tc++;
      step();
    end
    do_stop();
    checks++;
    if (tick_cnt !== 16'(exp_tc)) begin
      errors++;
      $display("FAIL cfg_idle_tick_cnt: got %0d expected %0d", tick_cnt, exp_tc);
    end
  endtask

  task automatic test_pending();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c <= 2; c++) begin
      checks++;
      if (clk_out !== (c < 5) || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL pend_pre c=%0d: clk_out=%b cfg_ready=%b expected %b 1", c, clk_out, cfg_ready, c < 5);
      end
      if (c == 2) begin
        cfg_valid = 1'b1;
        cfg_div   = 27'd4;
      end
      step();
      cfg_valid = 1'b0;
    end
    for (int c = 3; c <= 9; c++) begin
      checks++;
      if (clk_out !== (c < 5) || tick !== (c == 9) || cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL pend_old c=%0d: clk_out=%b tick=%b cfg_ready=%b expected %b %b 0",
                 c, clk_out, tick, cfg_ready, c < 5, c == 9);
      end
      step();
    end
    exp_tc++;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL pend_ready_back: got %b expected 1", cfg_ready);
    end
    for (int i = 0; i < 8; i++) begin
      int p;
      p = i % 4;
      checks++;
      if (clk_out !== (p < 2) || tick !== (p == 3)) begin
        errors++;
        $display("FAIL pend_new i=%0d: clk_out=%b tick=%b expected %b %b", i, clk_out, tick, p < 2, p == 3);
      end
      if (p == 3) exp_tc++;
      step();
    end
    checks++;
    if (tick_cnt !== 16'(exp_tc)) begin
      errors++;
      $display("FAIL pend_tick_cnt: got %0d expected %0d", tick_cnt, exp_tc);
    end
    do_stop();
  endtask

  task automatic test_cfg_err();
    cfg_valid = 1'b1;
    cfg_div   = 27'd10;
    step();
    for (int v = 1; v >= 0; v--) begin
      cfg_valid = 1'b1;
      cfg_div   = 27'(v);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL cfg_err_pulse div=%0d: cfg_err=%b cfg_ready=%b expected 1 1", v, cfg_err, cfg_ready);
      end
      step();
      checks++;
      if (cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_clear div=%0d: got %b expected 0", v, cfg_err);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      int p;
      p = (k - 1) % 10;
      checks++;
      if (clk_out !== (p < 5) || tick !== (p == 9)) begin
        errors++;
        $display("FAIL cfg_err_wave k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, p < 5, p == 9);
      end
      if (p == 9) exp_tc++;
      step();
    end
    do_stop();
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_same: busy=%b clk_out=%b expected 0 0", busy, clk_out);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL stop_on_tick_pre: tick=%b expected 1", tick);
    end
    do_stop();
    exp_tc++;
    checks++;
    if (busy !== 1'b0 || clk_out !== 1'b0 || tick !== 1'b0 || tick_cnt !== 16'(exp_tc)) begin
      errors++;
      $display("FAIL stop_on_tick: busy=%b clk_out=%b tick=%b tick_cnt=%0d expected 0 0 0 %0d",
               busy, clk_out, tick, tick_cnt, exp_tc);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    checks++;
    if (busy !== 1'b1 || tick_cnt !== 16'(exp_tc)) begin
      errors++;
      $display("FAIL reset_mid_pre: busy=%b tick_cnt=%0d expected 1 %0d", busy, tick_cnt, exp_tc);
    end
    reset = 1'b0;
    #1;
    exp_tc = 0;
    checks++;
    if (busy !== 1'b0 || clk_out !== 1'b0 || tick !== 1'b0 || tick_cnt !== 16'd0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b clk_out=%b tick=%b tick_cnt=%0d cfg_ready=%b expected 0 0 0 0 1",
               busy, clk_out, tick, tick_cnt, cfg_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if (tick !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle k=%0d: tick=%b busy=%b expected 0 0", k, tick, busy);
      end
    end
  endtask

  task automatic test_tick_wrap();
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    repeat (30) step();
    checks++;
    if (w_tick_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wrap_15: got %0d expected 15", w_tick_cnt);
    end
    repeat (4) step();
    checks++;
    if (w_tick_cnt !== 4'd1) begin
      errors++;
      $display("FAIL wrap_17: got %0d expected 1", w_tick_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_div10();
    test_cfg_idle();
    test_pending();
    test_cfg_err();
    test_start_stop();
    test_reset_mid();
    test_tick_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
- Run-time controller for the board clock-enable divider. Takes a 72 MHz system clock and produces a programmable-period tick, a near-50% divided clock, and a tick counter.
- Divisor is loaded over a valid/ready config handshake. Start/stop sequencing is glitch-free: a divisor change only takes effect at a period boundary.
- Sits between the top-level control logic and everything that consumes slow ticks (1 Hz default).

Parameters:
- CNT_W, 27, divisor/counter width; 27 bits covers 72_000_000.
- DEF_DIV, 72_000_000, divisor loaded at reset (1 Hz from 72 MHz).
- TCNT_W, 16, width of tick_cnt.

Ports:
- clock  in  1  system clock, 72 MHz.
- reset  in  1  asynchronous, active-low reset; asserted low, clears all state immediately.
- cfg_valid  in  1  new divisor presented on cfg_div.
- cfg_ready  out  1  block can accept a divisor this cycle.
- cfg_div  in  CNT_W  requested divisor, in clock cycles per output period.
- cfg_err  out  1  one-cycle pulse: accepted divisor was illegal (<2) and discarded.
- start  in  1  level/pulse; begin dividing from IDLE.
- stop  in  1  level/pulse; return to IDLE.
- busy  out  1  high while in RUN.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse at the last cycle of each period.
- tick_cnt  out  TCNT_W  count of ticks since reset, wraps.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, cnt=0, div_q=DEF_DIV, pend_v=0.
  - clk_out=0, tick=0, tick_cnt=0, cfg_err=0, busy=0, cfg_ready=1.
- FSM states: IDLE, RUN.
  - IDLE→RUN when start=1 and stop=0.
  - RUN→IDLE when stop=1; stop wins if asserted together with start.
  - start while in RUN is ignored.
- Start timing: start sampled at edge N.
  - Cycle N+1: RUN, cnt=0, clk_out=1, busy=1.
  - cnt increments each cycle and wraps from div_q-1 to 0.
- Divided clock: clk_out=1 for cnt < floor(div_q/2), else 0. Registered; no combinational path from cnt.
  - div_q=3: high 1 cycle, low 2.
  - div_q=2: 1/1.
- Tick: tick=1 in the cycle where cnt==div_q-1 in RUN. First tick comes div_q cycles after RUN entry. On each tick, tick_cnt increments by 1 and wraps 2^TCNT_W-1→0.
- Stop: next cycle is IDLE, cnt=0, clk_out=0, tick=0; tick_cnt and div_q are held. A stop arriving in the same cycle as a tick still emits that tick and increments tick_cnt.
- Config handshake: transfer occurs on cfg_valid & cfg_ready at a clock edge.
  - cfg_div<2: transfer completes; cfg_err=1 the next cycle only; nothing is stored.
  - IDLE, legal divisor: div_q=cfg_div the next cycle.
  - RUN, legal divisor: stored in pend_div, pend_v=1, cfg_ready=0 until applied.
  - Apply point: at the wrap edge (the cycle tick=1), div_q<=pend_div, pend_v<=0, cnt<=0. The new period starts immediately after the tick.
  - RUN→IDLE with pend_v=1: the pending value is applied on entry to IDLE.
- cfg_ready = !pend_v.
- A config transfer coinciding with start: the divisor applies before the first period (IDLE rule), and counting starts with the new divisor.
- Reset asserted mid-RUN: all outputs go to reset values asynchronously. Resumption requires a fresh start.
- Arithmetic: cnt, div_q and pend_div are unsigned CNT_W. Half-period = div_q>>1. No overflow is possible since cnt<div_q.

Decomposition:
- Package clkdiv_pkg:
  - state enum {IDLE, RUN}.
  - MIN_DIV=2.
  - default widths CNT_W/TCNT_W.
- Sub-module clkdiv_counter (CNT_W):
  - Inputs: clock, reset, run, div.
  - Outputs: cnt, wrap, half.
  - Owns the cnt register and compare logic.
- clkdiv_ctrl keeps the FSM, config handshake/pending logic, clk_out/tick registers and tick_cnt.

Test Plan:
- Reset, then start with DEF_DIV overridden to 10 → busy=1 next cycle; clk_out high 5, low 5; tick at cycles 10, 20, 30 after start; tick_cnt=3 after 30 cycles.
- In IDLE, cfg_div=3 accepted, then start → clk_out pattern 1,0,0 repeating; tick every 3 cycles.
- In RUN with div=10, cfg_div=4 accepted at cnt=2:
  - cfg_ready=0 until the next tick.
  - Period is 10 through that tick, 4 thereafter.
  - cfg_ready returns to 1 the cycle after the tick.
- cfg_div=1 and cfg_div=0 → cfg_err pulses once each; div_q unchanged; periods remain 10.
- start & stop in the same cycle from IDLE → stays IDLE. stop at cnt=9 (tick cycle) → tick emitted, tick_cnt incremented, IDLE next cycle with clk_out=0.
- reset low mid-period at cnt=6 → outputs cleared in the same cycle, tick_cnt=0; no tick without a new start. TCNT_W=4 run for 17 ticks → tick_cnt wraps to 1.
